bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter in front of the single data-side slave port of `bus`. It lets the core's data port (master 0) and a DMA/debug master (master 1) share that port. Each cycle it picks one requester by round-robin, or holds master 1 exclusively while a lock is active. It forwards the winner's request downstream and tracks in-flight accesses so that every `bus_rvalid_i`/`bus_rdata_i` is returned to the master that issued it.

## Interface
Parameters:
- `ADDR_W`, 15, width of the address field; must match `data_addr_i` of `bus`.
- `RSP_LAT`, 1, fixed downstream response latency in cycles (1..4); sets the depth of the owner pipeline.

Ports:
- `clk_i`  in  1  single clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `m0_req_i`, `m1_req_i`  in  1  request, held until granted.
- `m0_we_i`, `m1_we_i`  in  1  write enable.
- `m0_be_i`, `m1_be_i`  in  4  byte enables.
- `m0_addr_i`, `m1_addr_i`  in  ADDR_W  byte address.
- `m0_wdata_i`, `m1_wdata_i`  in  32  write data.
- `m1_lock_i`  in  1  master 1 requests exclusive ownership.
- `m0_gnt_o`, `m1_gnt_o`  out  1  request accepted this cycle.
- `m0_rvalid_o`, `m1_rvalid_o`  out  1  response valid.
- `m0_rdata_o`, `m1_rdata_o`  out  32  response data; 0 when the matching `rvalid` is low.
- `bus_req_o`  out  1  downstream request.
- `bus_we_o`, `bus_be_o`, `bus_addr_o`, `bus_wdata_o`  out  1/4/ADDR_W/32  downstream command, muxed from the winner.
- `bus_gnt_i`  in  1  downstream accept.
- `bus_rvalid_i`  in  1  downstream response valid.
- `bus_rdata_i`  in  32  downstream read data.
- `err_o`  out  1  sticky protocol error.

## Operation
- Winner selection is combinational each cycle:
  - One master requesting: that master wins.
  - Both requesting: the master named by the round-robin pointer `ptr` wins.
  - In LOCKED state: only master 1 may win; `m0_gnt_o` is held 0.
- Downstream command:
  - `bus_req_o` = winner exists.
  - `bus_we_o`, `bus_be_o`, `bus_addr_o`, `bus_wdata_o` = winner's fields.
  - All command fields are 0 when there is no winner.
- Grant:
  - `mX_gnt_o` = (winner == X) & `bus_gnt_i`.
  - Exactly one grant per accepted transfer.
- Pointer update:
  - On an accepted transfer, `ptr` moves to the non-winning master.
  - Otherwise `ptr` holds.
  - `ptr` reset value: master 0.
- Lock state machine:
  - UNLOCKED -> LOCKED when master 1 is granted with `m1_lock_i`=1.
  - LOCKED -> UNLOCKED on the first cycle `m1_lock_i`=0; master 0 is eligible in that same cycle.
  - `m1_lock_i` alone, without a grant to master 1, does not lock.
- Owner pipeline:
  - `RSP_LAT` stages, each holding {valid, id}.
  - Stage 0 loads {accepted transfer, winner id} every cycle and shifts each cycle.
  - Tail stage = owner of the response due this cycle.
- Response routing:
  - `bus_rvalid_i`=1 and tail valid: drive `m<id>_rvalid_o`=1 and `m<id>_rdata_o`=`bus_rdata_i`; the other master sees 0.
  - `bus_rvalid_i`=1 with tail invalid: the response is dropped and `err_o` is set.
  - Tail valid with `bus_rvalid_i`=0: the expected response is missing and `err_o` is set.
  - `err_o` clears only on reset.
- Writes also produce a response, because the downstream port returns `rvalid` for every request; writes are tracked identically to reads.

## Timing
- Reset (`rst_i`=0, asynchronous): all outputs 0; `ptr`=master 0; state UNLOCKED; owner pipeline cleared; `err_o`=0.
- Grant is same-cycle, zero latency: combinational from `req`, `ptr`, state and `bus_gnt_i`.
- Response appears on the master port in the same cycle as `bus_rvalid_i` (combinational).
- End-to-end response latency = `RSP_LAT` cycles after the grant.
- Throughput: one accepted transfer per cycle; back-to-back transfers alternate masters when both request.
- `bus_gnt_i`=0: no grant, `ptr` and state hold, stage 0 loads invalid.
- Reset mid-transaction: in-flight owners are discarded; no `rvalid` is forwarded after reset until a new transfer completes `RSP_LAT` cycles later.

## Test plan
- Single master: `m0` reads `0x0010` with `bus_gnt_i`=1 -> `bus_addr_o`=`0x0010` and `m0_gnt_o`=1 in the same cycle; next cycle `bus_rdata_i`=`0xDEADBEEF` gives `m0_rvalid_o`=1, `m0_rdata_o`=`0xDEADBEEF`, `m1_rvalid_o`=0.
- Fairness: both masters request continuously for 4 cycles after reset -> grants m0, m1, m0, m1; responses return in the same order, 1 cycle after each grant.
- Lock: `m1` request and lock for 3 cycles while `m0` also requests -> `m1_gnt_o`=1 for all 3 cycles, `m0_gnt_o`=0; `m0` is granted in the cycle `m1_lock_i` drops.
- Stall: both masters request with `bus_gnt_i`=0 for 2 cycles -> no grants, `ptr` unchanged, no `rvalid` 1 cycle later; then `bus_gnt_i`=1 -> m0 is granted.
- Spurious response: `bus_rvalid_i`=1 with no transfer in flight -> both master `rvalid` outputs 0, `err_o`=1 and it stays 1 for at least 10 cycles.
- Reset mid-operation: `rst_i`=0 asserted one cycle after an m1 grant -> all outputs 0 immediately; after release, `bus_rvalid_i` pulses with an empty pipeline -> `err_o`=1, no master `rvalid`.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter with master-1 lock in front of a single
// fixed-latency slave port; an owner pipeline steers each response back.
module bus_arbiter #(
    parameter int ADDR_W  = 15,
    parameter int RSP_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [3:0]        m0_be_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [31:0]       m0_wdata_i,
    output logic              m0_gnt_o,
    output logic              m0_rvalid_o,
    output logic [31:0]       m0_rdata_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [3:0]        m1_be_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [31:0]       m1_wdata_i,
    input  logic              m1_lock_i,
    output logic              m1_gnt_o,
    output logic              m1_rvalid_o,
    output logic [31:0]       m1_rdata_o,

    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_be_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_gnt_i,
    input  logic              bus_rvalid_i,
    input  logic [31:0]       bus_rdata_i,

    output logic              err_o
);

    localparam logic [0:0] ST_UNLOCKED = 1'b0;
    localparam logic [0:0] ST_LOCKED   = 1'b1;

    logic [0:0]         r_state;
    logic               r_ptr;
    logic [RSP_LAT-1:0] r_own_vld;
    logic [RSP_LAT-1:0] r_own_id;
    logic               r_err;

    logic               w_lock_active;
    logic               w_req0;
    logic               w_req1;
    logic               w_win_vld;
    logic               w_win_id;
    logic               w_xfer;
    logic               w_tail_vld;
    logic               w_tail_id;

    // The lock only excludes master 0 while m1_lock_i is still high, so the
    // cycle it drops already arbitrates normally.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned (which would infer a latch).
        w_lock_active = 1'b0;
        w_req0        = 1'b0;
        w_req1        = 1'b0;
        w_win_vld     = 1'b0;
        w_win_id      = 1'b0;
        w_xfer        = 1'b0;

        w_lock_active = (r_state == ST_LOCKED) && m1_lock_i;
        w_req0        = m0_req_i && !w_lock_active;
        w_req1        = m1_req_i;
        w_win_vld     = rst_i && (w_req0 || w_req1);
        w_win_id      = w_req1 && (!w_req0 || r_ptr);
        w_xfer        = w_win_vld && bus_gnt_i;
    end

    always_comb begin
        bus_req_o   = 1'b0;
        bus_we_o    = 1'b0;
        bus_be_o    = '0;
        bus_addr_o  = '0;
        bus_wdata_o = '0;
        m0_gnt_o    = 1'b0;
        m1_gnt_o    = 1'b0;

        if (w_win_vld) begin
            bus_req_o = 1'b1;
            if (w_win_id) begin
                bus_we_o    = m1_we_i;
                bus_be_o    = m1_be_i;
                bus_addr_o  = m1_addr_i;
                bus_wdata_o = m1_wdata_i;
                m1_gnt_o    = bus_gnt_i;
            end else begin
                bus_we_o    = m0_we_i;
                bus_be_o    = m0_be_i;
                bus_addr_o  = m0_addr_i;
                bus_wdata_o = m0_wdata_i;
                m0_gnt_o    = bus_gnt_i;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ptr   <= 1'b0;
            r_state <= ST_UNLOCKED;
        end else if (w_xfer) begin
            r_ptr <= ~w_win_id;
            if (r_state == ST_UNLOCKED) begin
                if (w_win_id && m1_lock_i) begin
                    r_state <= ST_LOCKED;
                end
            end else if (!m1_lock_i) begin
                r_state <= ST_UNLOCKED;
            end
        end else if (bus_gnt_i && (r_state == ST_LOCKED) && !m1_lock_i) begin
            r_state <= ST_UNLOCKED;
        end
    end

    // Owner pipeline: stage 0 records who was accepted, the tail names the
    // owner of the response arriving this cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_own_vld <= '0;
            r_own_id  <= '0;
        end else begin
            for (int i = RSP_LAT - 1; i > 0; i--) begin
                r_own_vld[i] <= r_own_vld[i-1];
                r_own_id[i]  <= r_own_id[i-1];
            end
            r_own_vld[0] <= w_xfer;
            r_own_id[0]  <= w_win_id;
        end
    end

    assign w_tail_vld = r_own_vld[RSP_LAT-1];
    assign w_tail_id  = r_own_id[RSP_LAT-1];

    always_comb begin
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = '0;
        m1_rdata_o  = '0;
        if (bus_rvalid_i && w_tail_vld) begin
            if (w_tail_id) begin
                m1_rvalid_o = 1'b1;
                m1_rdata_o  = bus_rdata_i;
            end else begin
                m0_rvalid_o = 1'b1;
                m0_rdata_o  = bus_rdata_i;
            end
        end
    end

    // Any disagreement between the expected owner and the slave's rvalid is
    // a protocol error that stays visible until reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (bus_rvalid_i != w_tail_vld) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: a stimulus process queues expected responses,
// a monitor pops and compares them whenever a response is presented.
module tb_bus_arbiter;

    localparam int ADDR_W = 15;

    localparam logic [ADDR_W-1:0] M0_ADDR  = 15'h0010;
    localparam logic [ADDR_W-1:0] M1_ADDR  = 15'h0200;
    localparam logic [31:0]       M0_WDATA = 32'h1111_1111;
    localparam logic [31:0]       M1_WDATA = 32'hCAFE_0001;
    localparam logic [3:0]        M0_BE    = 4'hF;
    localparam logic [3:0]        M1_BE    = 4'h3;

    typedef struct packed {
        logic        v0;
        logic        v1;
        logic [31:0] d0;
        logic [31:0] d1;
    } rsp_t;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              m0_req_i, m0_we_i, m0_gnt_o, m0_rvalid_o;
    logic [3:0]        m0_be_i;
    logic [ADDR_W-1:0] m0_addr_i;
    logic [31:0]       m0_wdata_i, m0_rdata_o;
    logic              m1_req_i, m1_we_i, m1_lock_i, m1_gnt_o, m1_rvalid_o;
    logic [3:0]        m1_be_i;
    logic [ADDR_W-1:0] m1_addr_i;
    logic [31:0]       m1_wdata_i, m1_rdata_o;
    logic              bus_req_o, bus_we_o, bus_gnt_i, bus_rvalid_i, err_o;
    logic [3:0]        bus_be_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [31:0]       bus_wdata_o, bus_rdata_i;

    rsp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    logic exp_err = 1'b0;

    bus_arbiter #(.ADDR_W(ADDR_W), .RSP_LAT(1)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i),
        .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_gnt_o(m0_gnt_o),
        .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
        .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_lock_i(m1_lock_i),
        .m1_gnt_o(m1_gnt_o), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_be_o(bus_be_o),
        .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o), .bus_gnt_i(bus_gnt_i),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented response is matched against the queue head.
    always @(negedge clk_i) begin
        rsp_t e;
        if (rst_i === 1'b1 && (bus_rvalid_i || m0_rvalid_o || m1_rvalid_o)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {62'd0, m0_rvalid_o, m1_rvalid_o}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("m0_rvalid", {63'd0, m0_rvalid_o}, {63'd0, e.v0});
                check("m1_rvalid", {63'd0, m1_rvalid_o}, {63'd0, e.v1});
                check("m0_rdata",  {32'd0, m0_rdata_o},  {32'd0, e.d0});
                check("m1_rdata",  {32'd0, m1_rdata_o},  {32'd0, e.d1});
            end
        end
    end

    // One clock of stimulus. win: expected winner (-1 none); rsp: owner of the
    // response driven this cycle (-1 = no owner, i.e. spurious).
    task automatic cyc(input logic r0, input logic r1, input logic lk, input logic g,
                       input logic rv, input logic [31:0] rd, input int win, input int rsp);
        rsp_t e;
        logic gexp;
        m0_req_i     = r0;
        m1_req_i     = r1;
        m1_lock_i    = lk;
        bus_gnt_i    = g;
        bus_rvalid_i = rv;
        bus_rdata_i  = rv ? rd : 32'd0;
        if (rv) begin
            e.v0 = (rsp == 0);
            e.v1 = (rsp == 1);
            e.d0 = (rsp == 0) ? rd : 32'd0;
            e.d1 = (rsp == 1) ? rd : 32'd0;
            exp_q.push_back(e);
        end
        @(negedge clk_i);
        gexp = g;
        check("m0_gnt",  {63'd0, m0_gnt_o},  {63'd0, (win == 0) && gexp});
        check("m1_gnt",  {63'd0, m1_gnt_o},  {63'd0, (win == 1) && gexp});
        check("bus_req", {63'd0, bus_req_o}, {63'd0, win >= 0});
        check("bus_addr", {49'd0, bus_addr_o},
              {49'd0, (win == 0) ? M0_ADDR : (win == 1) ? M1_ADDR : 15'd0});
        check("bus_we",  {63'd0, bus_we_o},  {63'd0, win == 1});
        check("bus_be",  {60'd0, bus_be_o},
              {60'd0, (win == 0) ? M0_BE : (win == 1) ? M1_BE : 4'd0});
        check("bus_wdata", {32'd0, bus_wdata_o},
              {32'd0, (win == 0) ? M0_WDATA : (win == 1) ? M1_WDATA : 32'd0});
        if (!rv) check("rvalid_idle", {62'd0, m0_rvalid_o, m1_rvalid_o}, 64'd0);
        check("err", {63'd0, err_o}, {63'd0, exp_err});
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_bus_req"}, {63'd0, bus_req_o}, 64'd0);
        check({tag, "_gnts"},    {62'd0, m0_gnt_o, m1_gnt_o}, 64'd0);
        check({tag, "_rvalids"}, {62'd0, m0_rvalid_o, m1_rvalid_o}, 64'd0);
        check({tag, "_rdata"},   {m0_rdata_o, m1_rdata_o}, 64'd0);
        check({tag, "_cmd"},     {bus_wdata_o, 11'd0, bus_addr_o, bus_be_o, 1'b0, bus_we_o}, 64'd0);
        check({tag, "_err"},     {63'd0, err_o}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_i      = 1'b0;
        m0_we_i    = 1'b0;  m0_be_i = M0_BE;  m0_addr_i = M0_ADDR;  m0_wdata_i = M0_WDATA;
        m1_we_i    = 1'b1;  m1_be_i = M1_BE;  m1_addr_i = M1_ADDR;  m1_wdata_i = M1_WDATA;
        m0_req_i   = 1'b1;  m1_req_i = 1'b1;  m1_lock_i = 1'b0;
        bus_gnt_i  = 1'b1;  bus_rvalid_i = 1'b1;  bus_rdata_i = 32'hFFFF_FFFF;

        // Reset state, with active inputs that must not leak through.
        @(negedge clk_i);
        check_all_zero("reset");
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // Single master read.
        cyc(1, 0, 0, 1, 0, 32'd0,        0, -1);
        cyc(0, 0, 0, 1, 1, 32'hDEADBEEF, -1, 0);

        // Fairness from a fresh reset.
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        cyc(1, 1, 0, 1, 0, 32'd0,        0, -1);
        cyc(1, 1, 0, 1, 1, 32'hA000_0000, 1, 0);
        cyc(1, 1, 0, 1, 1, 32'hA000_0001, 0, 1);
        cyc(1, 1, 0, 1, 1, 32'hA000_0002, 1, 0);
        cyc(0, 0, 0, 1, 1, 32'hA000_0003, -1, 1);

        // Lock: pointer first moved to m1, then m1 holds through RR turns.
        cyc(1, 0, 0, 1, 0, 32'd0,        0, -1);
        cyc(1, 1, 1, 1, 1, 32'hB000_0000, 1, 0);
        cyc(1, 1, 1, 1, 1, 32'hB000_0001, 1, 1);
        cyc(1, 1, 1, 1, 1, 32'hB000_0002, 1, 1);
        cyc(1, 1, 0, 1, 1, 32'hB000_0003, 0, 1);
        cyc(0, 1, 0, 1, 1, 32'hB000_0004, 1, 0);

        // Stall: no grant, pointer held, then m0 wins.
        cyc(1, 1, 0, 0, 1, 32'hB000_0005, 0, 1);
        cyc(1, 1, 0, 0, 0, 32'd0,         0, -1);
        cyc(1, 1, 0, 1, 0, 32'd0,         0, -1);

        // Lock request without a grant must not lock.
        cyc(0, 1, 1, 0, 1, 32'hC000_0000, 1, 0);
        cyc(1, 0, 1, 1, 0, 32'd0,         0, -1);
        cyc(0, 0, 0, 1, 1, 32'hC000_0001, -1, 0);

        // Spurious response: dropped, err sticks.
        cyc(0, 0, 0, 1, 1, 32'h0000_0BAD, -1, -1);
        exp_err = 1'b1;
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 1, 0, 32'd0, -1, -1);

        // Reset one cycle after an m1 grant.
        cyc(0, 1, 0, 1, 0, 32'd0, 1, -1);
        rst_i        = 1'b0;
        m0_req_i     = 1'b1;
        m1_req_i     = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1234_5678;
        @(negedge clk_i);
        check_all_zero("midreset");
        @(posedge clk_i); #1;
        rst_i   = 1'b1;
        exp_err = 1'b0;
        cyc(0, 0, 0, 1, 0, 32'd0,        -1, -1);
        cyc(0, 0, 0, 1, 1, 32'h0000_0055, -1, -1);
        exp_err = 1'b1;
        cyc(0, 0, 0, 1, 0, 32'd0,        -1, -1);

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
